// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants for the instruction-fetch stage: reset PC,
//               instruction-memory window defaults and the NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Default PC after reset and start of the instruction-memory window
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam int          DEF_IM_WORDS = 1024;

    // Last word-aligned byte address inside the default window
    localparam logic [31:0] DEF_IM_END   = DEF_IM_BASE + 32'(4 * DEF_IM_WORDS) - 32'd4;

    // Bubble / faulting-fetch instruction (sll $0,$0,0)
    localparam logic [31:0] NOP          = 32'h0000_0000;

    // Last valid byte address of a window of the given base and size
    function automatic logic [31:0] window_end(input logic [31:0] base, input int words);
        return base + 32'(4 * words) - 32'd4;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Next-PC priority mux (flush/redirect, stall, redirect, PC+4)
//               and the fetch-address fault comparator for the current PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel #(
    parameter logic [31:0] IM_BASE = 32'h0000_3000,
    parameter logic [31:0] IM_END  = 32'h0000_3FFC
) (
    input  logic [31:0] pc_q,
    input  logic        flush,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_d,
    output logic        fault
);

    // Next PC: exception entry beats stall; a plain redirect waits for stall to drop
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (flush) begin
            pc_d = redirect_valid ? redirect_pc : pc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    // Misaligned or outside the instruction-memory window
    assign fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_END);

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : MIPS instruction-fetch stage. Owns the PC, drives the
//               instruction memory, and registers the returned word into the
//               IF/ID register with fault tagging and a retired-fetch count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter int          IM_WORDS = DEF_IM_WORDS,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic [31:0]      IM_Out,
    output logic [31:0]      PC_Out,
    output logic [31:0]      IR_D,
    output logic [31:0]      PC_D,
    output logic [31:0]      PC8_D,
    output logic             valid_D,
    output logic             fault_D,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [31:0] IM_END = window_end(IM_BASE, IM_WORDS);

    logic [31:0]      pc_q,    pc_d;
    logic [31:0]      ir_q,    ir_d;
    logic [31:0]      pcd_q,   pcd_d;
    logic [31:0]      pc8_q,   pc8_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             w_fault;

    pc_next_sel #(
        .IM_BASE (IM_BASE),
        .IM_END  (IM_END)
    ) u_pc_next_sel (
        .pc_q           (pc_q),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_d           (pc_d),
        .fault          (w_fault)
    );

    // IF/ID next state: flush bubbles, stall holds, otherwise capture the fetch
    always_comb begin
        ir_d    = ir_q;
        pcd_d   = pcd_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        if (flush) begin
            ir_d    = NOP;
            pcd_d   = 32'd0;
            pc8_d   = 32'd0;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!stall) begin
            ir_d    = w_fault ? NOP : IM_Out;
            pcd_d   = pc_q;
            pc8_d   = pc_q + 32'd8;
            valid_d = 1'b1;
            fault_d = w_fault;
            if (!w_fault) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // PC, IF/ID and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            pcd_q   <= 32'd0;
            pc8_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcd_q   <= pcd_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC_Out    = pc_q;
    assign IR_D      = ir_q;
    assign PC_D      = pcd_q;
    assign PC8_D     = pc8_q;
    assign valid_D   = valid_q;
    assign fault_D   = fault_q;
    assign fetch_cnt = cnt_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] im_out;
    logic [31:0] pc_out, ir_d, pc_d, pc8_d, fetch_cnt;
    logic        valid_d, fault_d;

    int checks = 0;
    int fails  = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .IM_Out         (im_out),
        .PC_Out         (pc_out),
        .IR_D           (ir_d),
        .PC_D           (pc_d),
        .PC8_D          (pc8_d),
        .valid_D        (valid_d),
        .fault_D        (fault_d),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: distinct word per address
    function automatic logic [31:0] im(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign im_out = im(pc_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                            input logic [31:0] pcd, input logic v, input logic f,
                            input logic [31:0] cnt);
        chk({tag, ".pc"},    pc_out,       pc);
        chk({tag, ".ir"},    ir_d,         ir);
        chk({tag, ".pcd"},   pc_d,         pcd);
        chk({tag, ".pc8"},   pc8_d,        (v && !f && pcd == 32'd0) ? 32'd0 : (v ? pcd + 32'd8 : 32'd0));
        chk({tag, ".valid"}, 32'(valid_d), 32'(v));
        chk({tag, ".fault"}, 32'(fault_d), 32'(f));
        chk({tag, ".cnt"},   fetch_cnt,    cnt);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk_ifid("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        #2 reset = 1'b0;

        // Sequential fetch
        step();
        chk_ifid("seq0", 32'h3004, im(32'h3000), 32'h3000, 1'b1, 1'b0, 32'd1);
        chk("seq0.pc8abs", pc8_d, 32'h3008);
        step();
        chk_ifid("seq1", 32'h3008, im(32'h3004), 32'h3004, 1'b1, 1'b0, 32'd2);

        // Stall two cycles at 0x3008
        stall = 1'b1;
        step();
        chk_ifid("stall0", 32'h3008, im(32'h3004), 32'h3004, 1'b1, 1'b0, 32'd2);
        step();
        chk_ifid("stall1", 32'h3008, im(32'h3004), 32'h3004, 1'b1, 1'b0, 32'd2);
        stall = 1'b0;
        step();
        chk_ifid("unstall", 32'h300C, im(32'h3008), 32'h3008, 1'b1, 1'b0, 32'd3);
        step();
        chk_ifid("seq2", 32'h3010, im(32'h300C), 32'h300C, 1'b1, 1'b0, 32'd4);

        // Redirect with delay slot
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        step();
        chk_ifid("redir_ds", 32'h3100, im(32'h3010), 32'h3010, 1'b1, 1'b0, 32'd5);
        redirect_valid = 1'b0;
        step();
        chk_ifid("redir_tgt", 32'h3104, im(32'h3100), 32'h3100, 1'b1, 1'b0, 32'd6);

        // Redirect held across a stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3200;
        stall          = 1'b1;
        step();
        chk_ifid("rstall0", 32'h3104, im(32'h3100), 32'h3100, 1'b1, 1'b0, 32'd6);
        step();
        chk_ifid("rstall1", 32'h3104, im(32'h3100), 32'h3100, 1'b1, 1'b0, 32'd6);
        stall = 1'b0;
        step();
        chk_ifid("rstall_go", 32'h3200, im(32'h3104), 32'h3104, 1'b1, 1'b0, 32'd7);
        redirect_valid = 1'b0;
        step();
        chk_ifid("rstall_tgt", 32'h3204, im(32'h3200), 32'h3200, 1'b1, 1'b0, 32'd8);

        // Flush + stall + redirect out of window
        flush          = 1'b1;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4180;
        step();
        chk_ifid("flush_exc", 32'h4180, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk_ifid("oow_fault", 32'h4184, 32'h0, 32'h4180, 1'b1, 1'b1, 32'd8);
        chk("oow_fault.pc8abs", pc8_d, 32'h4188);

        // Flush without redirect holds the PC
        flush = 1'b1;
        step();
        chk_ifid("flush_hold", 32'h4184, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);
        flush = 1'b0;

        // Unaligned redirect, then jump near the window end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3002;
        step();
        chk_ifid("unal_load", 32'h3002, 32'h0, 32'h4184, 1'b1, 1'b1, 32'd8);
        redirect_pc = 32'h3FF8;
        step();
        chk_ifid("unal_fault", 32'h3FF8, 32'h0, 32'h3002, 1'b1, 1'b1, 32'd8);
        redirect_valid = 1'b0;
        step();
        chk_ifid("end_m1", 32'h3FFC, im(32'h3FF8), 32'h3FF8, 1'b1, 1'b0, 32'd9);
        step();
        chk_ifid("end_last", 32'h4000, im(32'h3FFC), 32'h3FFC, 1'b1, 1'b0, 32'd10);
        step();
        chk_ifid("end_over", 32'h4004, 32'h0, 32'h4000, 1'b1, 1'b1, 32'd10);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_load.pc", pc_out, 32'hFFFF_FFFC);
        step();
        chk("wrap.pc", pc_out, 32'h0000_0000);
        chk("wrap.pcd", pc_d, 32'hFFFF_FFFC);
        chk("wrap.pc8", pc8_d, 32'h0000_0004);
        chk("wrap.fault", 32'(fault_d), 32'd1);
        step();
        chk("wrap0.pc", pc_out, 32'h0000_0004);
        chk("wrap0.fault", 32'(fault_d), 32'd1);
        chk("wrap0.cnt", fetch_cnt, 32'd10);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        chk_ifid("async_rst", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS pipeline: owns the PC register, drives PC_Out to the instruction memory, and captures the returned IM_Out word into the IF/ID pipeline register.
- Sequential PC+4 advance, stall hold, branch/jump redirect with the delay slot preserved, flush bubble insertion.
- Address-window and alignment fault detection, plus a retired-fetch counter.
- Sits between the hazard/branch logic (D stage) and the instruction memory.

Parameters:
RESET_PC, 32'h00003000, PC value after reset
IM_BASE, 32'h00003000, first byte address of the instruction memory window
IM_WORDS, 1024, window size in 32-bit words (window = IM_BASE .. IM_BASE+4*IM_WORDS-4)
CNT_W, 32, fetch counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID (load-use / mult-busy hazard)
flush  in  1  replace IF/ID with a bubble; highest priority
redirect_valid  in  1  branch/jump/exception target valid
redirect_pc  in  32  redirect target byte address
IM_Out  in  32  instruction word returned combinationally for PC_Out
PC_Out  out  32  current fetch address to the instruction memory
IR_D  out  32  IF/ID instruction
PC_D  out  32  IF/ID PC of IR_D
PC8_D  out  32  PC_D+8 (link address)
valid_D  out  1  IF/ID holds a real instruction
fault_D  out  1  IR_D came from a faulting fetch address
fetch_cnt  out  CNT_W  count of valid non-faulting fetches accepted into IF/ID

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - PC <= RESET_PC; IR_D, PC_D, PC8_D, fetch_cnt <= 0; valid_D, fault_D <= 0.
- PC_Out equals the PC register combinationally; there is no extra latency. The IM responds in the same cycle, and IR_D is registered on the next rising edge, so fetch-to-D latency is 1 cycle.
- Fault condition on the current PC: PC[1:0] != 0, or PC < IM_BASE, or PC > IM_BASE+4*IM_WORDS-4.
  - A faulting fetch loads IR_D <= 32'h0 (nop), fault_D <= 1, valid_D <= 1.
  - fetch_cnt is not incremented.
  - The PC still advances normally, so the exception logic can redirect it.
- Per-edge priority for the IF/ID register:
  1. flush=1: IR_D <= 0, PC_D <= 0, PC8_D <= 0, valid_D <= 0, fault_D <= 0. This holds regardless of stall.
  2. stall=1: IF/ID holds all values.
  3. Otherwise: IR_D <= IM_Out (or 0 on fault), PC_D <= PC, PC8_D <= PC+8, valid_D <= 1, fault_D <= fault.
- Per-edge priority for the PC:
  1. flush=1 and redirect_valid=1: PC <= redirect_pc (exception entry; overrides stall).
  2. flush=1 and redirect_valid=0: PC holds.
  3. stall=1: PC holds, and redirect_valid is ignored.
  4. redirect_valid=1: PC <= redirect_pc. The instruction fetched in this cycle (the delay slot) is still loaded into IF/ID normally.
  5. Otherwise: PC <= PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 0 and then faults).
- Redirect handshake:
  - A redirect is accepted only on an edge with stall=0 or flush=1.
  - The source must hold redirect_valid and redirect_pc stable until that edge.
  - An unaligned redirect_pc is loaded as-is and produces fault_D on its fetch.
- Window boundary: sequential fetch from IM_BASE+4*IM_WORDS-4 (32'h00003FFC by default) moves to 32'h00004000, which faults.
- fetch_cnt increments by 1 on each edge where IF/ID loads with fault=0 and flush=0. It wraps from all-ones to 0 and never saturates.

Decomposition:
- Shared package holds the RESET_PC/IM_BASE defaults, the NOP constant 32'h0, and the window-end constant.
- One natural sub-module, pc_next_sel: a combinational priority mux (flush/stall/redirect/PC+4) plus the fault comparator. The IF/ID register and the counter stay in fetch_unit.

Test Plan:
- Reset, then 3 cycles with no stall: PC_Out 0x3000→0x3004→0x3008→0x300C; IR_D/PC_D track IM_Out and 0x3000/0x3004; PC8_D=0x3008 with PC_D=0x3000; fetch_cnt=3.
- stall=1 for 2 cycles at PC=0x3008: PC_Out stays 0x3008 and IR_D/PC_D unchanged; after release, IR_D=IM(0x3008) next edge.
- redirect_valid=1, redirect_pc=0x3100 at PC=0x3010: next PC_Out=0x3100 and IR_D=IM(0x3010) (delay slot kept, valid_D=1); then IR_D=IM(0x3100).
- redirect held with stall=1 for 2 cycles, then stall=0: PC unchanged during stall, becomes redirect_pc exactly one edge after stall drops.
- flush=1 with stall=1 and redirect_pc=0x4180 (out of window): valid_D=0, IR_D=0; next PC_Out=0x4180; following edge fault_D=1, IR_D=0, fetch_cnt unchanged.
- Sequential run through 0x3FFC: IR_D=IM(0x3FFC) with fault_D=0, then PC_Out=0x4000 yields fault_D=1; assert reset mid-cycle → PC_Out=0x3000 immediately and all outputs are 0 without waiting for a clock edge.
